// File: rtl/csr_pkg.sv
// Shared types and helpers for the CSR Avalon-MM responder.
// Holds the FSM state encoding, response codes and the byte-enable expander.
package csr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        RVALID = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Native bus width of the register bank; other widths expand inline in the top.
    localparam int CSR_DATA_WIDTH = 32;
    localparam int CSR_BE_WIDTH   = CSR_DATA_WIDTH / 8;

    function automatic logic [CSR_DATA_WIDTH-1:0] be_to_bitmask(input logic [CSR_BE_WIDTH-1:0] be);
        logic [CSR_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < CSR_BE_WIDTH; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/csr_avmm_responder_if.sv
// Avalon-MM host-bus bundle between the sequencer host and the CSR responder.
// Handshake: a command is accepted in the single cycle WAITREQUEST is low; read data
// is valid only in the cycle READDATAVALID is high, with RESPONSE qualified alongside it.
interface csr_avmm_responder_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 4
);
    logic [P_ADDR_WIDTH-1:0]   AVS_ADDRESS;
    logic                      AVS_READ;
    logic                      AVS_WRITE;
    logic [P_DATA_WIDTH-1:0]   AVS_WRITEDATA;
    logic [P_DATA_WIDTH/8-1:0] AVS_BYTEENABLE;
    logic                      AVS_WAITREQUEST;
    logic [P_DATA_WIDTH-1:0]   AVS_READDATA;
    logic                      AVS_READDATAVALID;
    logic [1:0]                AVS_RESPONSE;

    modport master (
        output AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA, AVS_BYTEENABLE,
        input  AVS_WAITREQUEST, AVS_READDATA, AVS_READDATAVALID, AVS_RESPONSE
    );

    modport slave (
        input  AVS_ADDRESS, AVS_READ, AVS_WRITE, AVS_WRITEDATA, AVS_BYTEENABLE,
        output AVS_WAITREQUEST, AVS_READDATA, AVS_READDATAVALID, AVS_RESPONSE
    );
endinterface

// File: rtl/csr_addr_decode.sv
// Word address to one-hot register select; in_range is simply "some register matched".
module csr_addr_decode #(
    parameter int P_NUM_REGS   = 8,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic [P_ADDR_WIDTH-1:0] addr_i,
    output logic [P_NUM_REGS-1:0]   select_o,
    output logic                    in_range_o
);

    always_comb begin
        select_o = '0;
        for (int k = 0; k < P_NUM_REGS; k++) begin
            if (addr_i == P_ADDR_WIDTH'(k)) begin
                select_o[k] = 1'b1;
            end
        end
        in_range_o = |select_o;
    end

endmodule

// File: rtl/csr_avmm_responder.sv
// Avalon-MM slave front-end for the sequencer CSR bank: decodes writes into
// single-cycle register strobes and returns read data one cycle after accept.
module csr_avmm_responder
    import csr_pkg::*;
#(
    parameter int P_NUM_REGS   = 8,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 4
) (
    input  logic                             CLOCK,
    input  logic                             RESET_N,
    csr_avmm_responder_if.slave              avs,
    output logic [P_NUM_REGS-1:0]            REG_SELECT,
    output logic                             REG_WRITE,
    output logic [P_DATA_WIDTH-1:0]          REG_ENA,
    output logic [P_DATA_WIDTH-1:0]          REG_DATA,
    input  logic [P_NUM_REGS*P_DATA_WIDTH-1:0] REG_RDATA,
    output state_e                           DBG_STATE
);

    state_e                    state_q;
    logic [P_ADDR_WIDTH-1:0]   addr_q;
    logic                      is_read_q;
    logic                      waitreq_q;
    logic                      rvalid_q;
    logic [P_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                resp_q;
    logic [P_NUM_REGS-1:0]     sel_q;
    logic                      wr_q;
    logic [P_DATA_WIDTH-1:0]   ena_q;
    logic [P_DATA_WIDTH-1:0]   data_q;

    logic [P_ADDR_WIDTH-1:0]   dec_addr;
    logic [P_NUM_REGS-1:0]     dec_sel;
    logic                      dec_in_range;
    logic [P_DATA_WIDTH-1:0]   be_mask;
    logic [P_DATA_WIDTH-1:0]   rd_mux;

    // Write strobes are registered off the live bus address at capture; the read
    // mux uses the latched address while the ACK cycle samples the register bank.
    assign dec_addr = (state_q == IDLE) ? avs.AVS_ADDRESS : addr_q;

    csr_addr_decode #(
        .P_NUM_REGS   (P_NUM_REGS),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_decode (
        .addr_i     (dec_addr),
        .select_o   (dec_sel),
        .in_range_o (dec_in_range)
    );

    if (P_DATA_WIDTH == CSR_DATA_WIDTH) begin : g_pkg_mask
        assign be_mask = be_to_bitmask(avs.AVS_BYTEENABLE);
    end else begin : g_local_mask
        always_comb begin
            be_mask = '0;
            for (int i = 0; i < P_DATA_WIDTH / 8; i++) begin
                be_mask[i*8 +: 8] = {8{avs.AVS_BYTEENABLE[i]}};
            end
        end
    end

    // One-hot select makes the read mux an OR of gated slices; out of range yields zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < P_NUM_REGS; k++) begin
            if (dec_sel[k]) begin
                rd_mux = rd_mux | REG_RDATA[k*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            waitreq_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            sel_q     <= '0;
            wr_q      <= 1'b0;
            ena_q     <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (avs.AVS_WRITE || avs.AVS_READ) begin
                        // A simultaneous read+write is taken as a write only.
                        addr_q    <= avs.AVS_ADDRESS;
                        is_read_q <= !avs.AVS_WRITE;
                        waitreq_q <= 1'b0;
                        state_q   <= ACK;
                        if (avs.AVS_WRITE && dec_in_range) begin
                            sel_q  <= dec_sel;
                            wr_q   <= 1'b1;
                            ena_q  <= be_mask;
                            data_q <= avs.AVS_WRITEDATA;
                        end
                    end
                end
                ACK: begin
                    waitreq_q <= 1'b1;
                    sel_q     <= '0;
                    wr_q      <= 1'b0;
                    ena_q     <= '0;
                    if (is_read_q) begin
                        rdata_q  <= rd_mux;
                        resp_q   <= dec_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q <= 1'b1;
                        state_q  <= RVALID;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RVALID: begin
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign avs.AVS_WAITREQUEST   = waitreq_q;
    assign avs.AVS_READDATAVALID = rvalid_q;
    assign avs.AVS_READDATA      = rdata_q;
    assign avs.AVS_RESPONSE      = resp_q;
    assign REG_SELECT            = sel_q;
    assign REG_WRITE             = wr_q;
    assign REG_ENA               = ena_q;
    assign REG_DATA              = data_q;
    assign DBG_STATE             = state_q;

endmodule

// File: tb/tb_csr_avmm_responder.sv
// Directed plus randomized bench for csr_avmm_responder against a bytewise
// register-bank model kept in plain arrays.
module tb_csr_avmm_responder;
    import csr_pkg::*;

    localparam int NR = 8;
    localparam int W  = 32;
    localparam int AW = 4;

    logic              CLOCK = 1'b0;
    logic              RESET_N;
    logic [NR-1:0]     reg_select;
    logic              reg_write;
    logic [W-1:0]      reg_ena;
    logic [W-1:0]      reg_data;
    logic [NR*W-1:0]   reg_rdata;
    state_e            dbg_state;

    csr_avmm_responder_if #(.P_DATA_WIDTH(W), .P_ADDR_WIDTH(AW)) bus ();

    csr_avmm_responder #(
        .P_NUM_REGS   (NR),
        .P_DATA_WIDTH (W),
        .P_ADDR_WIDTH (AW)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .avs        (bus),
        .REG_SELECT (reg_select),
        .REG_WRITE  (reg_write),
        .REG_ENA    (reg_ena),
        .REG_DATA   (reg_data),
        .REG_RDATA  (reg_rdata),
        .DBG_STATE  (dbg_state)
    );

    // clock / reset
    always #5 CLOCK = ~CLOCK;

    // environment register bank driven by the DUT strobes
    logic [W-1:0] bank [NR];
    logic [W-1:0] init_vals [NR];
    logic         preload;

    always @(posedge CLOCK) begin
        if (preload) begin
            for (int k = 0; k < NR; k++) bank[k] <= init_vals[k];
        end else if (reg_write) begin
            for (int k = 0; k < NR; k++) begin
                if (reg_select[k]) bank[k] <= (bank[k] & ~reg_ena) | (reg_data & reg_ena);
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int k = 0; k < NR; k++) reg_rdata[k*W +: W] = bank[k];
    end

    // scoreboard / reference model
    logic [W-1:0] exp_bank [NR];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_wdata;
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [W-1:0] d, input logic [3:0] be);
        if (a < NR) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) exp_bank[a][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    // driver tasks
    task automatic do_write(input int a, input logic [W-1:0] d, input logic [3:0] be);
        logic [W-1:0]  e_ena;
        logic [NR-1:0] e_sel;
        logic          in_r;
        in_r  = (a < NR);
        e_sel = in_r ? NR'(1 << a) : '0;
        for (int b = 0; b < 4; b++) e_ena[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
        @(negedge CLOCK);
        bus.AVS_ADDRESS    = AW'(a);
        bus.AVS_WRITEDATA  = d;
        bus.AVS_BYTEENABLE = be;
        bus.AVS_WRITE      = 1'b1;
        @(posedge CLOCK); #1;
        bus.AVS_WRITE      = 1'b0;
        bus.AVS_WRITEDATA  = $urandom;
        bus.AVS_BYTEENABLE = 4'($urandom);
        check("wr_ack_waitreq", 64'(bus.AVS_WAITREQUEST), 64'(0));
        check("wr_ack_select",  64'(reg_select), 64'(e_sel));
        check("wr_ack_strobe",  64'(reg_write), 64'(in_r));
        if (in_r) begin
            check("wr_ack_ena",  64'(reg_ena), 64'(e_ena));
            check("wr_ack_data", 64'(reg_data), 64'(d));
            last_wdata = d;
        end
        model_write(a, d, be);
        @(posedge CLOCK); #1;
        check("wr_idle_waitreq", 64'(bus.AVS_WAITREQUEST), 64'(1));
        check("wr_idle_select",  64'(reg_select), 64'(0));
        check("wr_idle_strobe",  64'(reg_write), 64'(0));
        check("wr_idle_ena",     64'(reg_ena), 64'(0));
        check("wr_idle_rvalid",  64'(bus.AVS_READDATAVALID), 64'(0));
        if (in_r) check("wr_idle_data_hold", 64'(reg_data), 64'(last_wdata));
    endtask

    task automatic do_read(input int a);
        logic [W-1:0] e_data;
        logic [1:0]   e_resp;
        exp_q.push_back((a < NR) ? exp_bank[a] : '0);
        e_resp = (a < NR) ? RESP_OKAY : RESP_SLVERR;
        @(negedge CLOCK);
        bus.AVS_ADDRESS = AW'(a);
        bus.AVS_READ    = 1'b1;
        @(posedge CLOCK); #1;
        bus.AVS_READ    = 1'b0;
        bus.AVS_ADDRESS = AW'($urandom);
        check("rd_ack_waitreq", 64'(bus.AVS_WAITREQUEST), 64'(0));
        check("rd_ack_rvalid",  64'(bus.AVS_READDATAVALID), 64'(0));
        check("rd_ack_strobe",  64'(reg_write), 64'(0));
        @(posedge CLOCK); #1;
        e_data = exp_q.pop_front();
        check("rd_rvalid",   64'(bus.AVS_READDATAVALID), 64'(1));
        check("rd_data",     64'(bus.AVS_READDATA), 64'(e_data));
        check("rd_response", 64'(bus.AVS_RESPONSE), 64'(e_resp));
        check("rd_rv_waitreq", 64'(bus.AVS_WAITREQUEST), 64'(1));
        @(posedge CLOCK); #1;
        check("rd_rvalid_drop", 64'(bus.AVS_READDATAVALID), 64'(0));
        check("rd_data_hold",   64'(bus.AVS_READDATA), 64'(e_data));
        check("rd_resp_hold",   64'(bus.AVS_RESPONSE), 64'(e_resp));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_waitreq"}, 64'(bus.AVS_WAITREQUEST), 64'(1));
        check({tag, "_rvalid"},  64'(bus.AVS_READDATAVALID), 64'(0));
        check({tag, "_rdata"},   64'(bus.AVS_READDATA), 64'(0));
        check({tag, "_resp"},    64'(bus.AVS_RESPONSE), 64'(0));
        check({tag, "_select"},  64'(reg_select), 64'(0));
        check({tag, "_strobe"},  64'(reg_write), 64'(0));
        check({tag, "_ena"},     64'(reg_ena), 64'(0));
        check({tag, "_data"},    64'(reg_data), 64'(0));
        check({tag, "_state"},   64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        RESET_N            = 1'b0;
        bus.AVS_ADDRESS    = '0;
        bus.AVS_READ       = 1'b0;
        bus.AVS_WRITE      = 1'b0;
        bus.AVS_WRITEDATA  = '0;
        bus.AVS_BYTEENABLE = '0;
        last_wdata         = '0;
        for (int k = 0; k < NR; k++) init_vals[k] = $urandom;
        init_vals[5] = 32'hDEAD_BEEF;
        for (int k = 0; k < NR; k++) exp_bank[k] = init_vals[k];
        preload = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_values("reset");
        @(negedge CLOCK);
        preload = 1'b0;
        RESET_N = 1'b1;

        do_write(2, 32'hA5A5_1234, 4'hF);
        do_write(0, 32'h1357_9BDF, 4'b0010);
        do_write(0, 32'hFFFF_FFFF, 4'b0000);
        do_read(5);
        do_read(0);
        do_read(9);
        do_write(9, 32'h0BAD_F00D, 4'hF);
        do_write(3, 32'hCAFE_0003, 4'hF);
        do_read(3);

        // reset pulsed during the ACK of a read: no data may ever come back
        @(negedge CLOCK);
        bus.AVS_ADDRESS = AW'(3);
        bus.AVS_READ    = 1'b1;
        @(posedge CLOCK); #1;
        bus.AVS_READ = 1'b0;
        check("rst_rd_ack_waitreq", 64'(bus.AVS_WAITREQUEST), 64'(0));
        RESET_N = 1'b0;
        #1;
        check_reset_values("midrst");
        last_wdata = '0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLOCK); #1;
            check("midrst_no_rvalid", 64'(bus.AVS_READDATAVALID), 64'(0));
        end

        for (int n = 0; n < 60; n++) begin
            int a;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else do_read(a);
        end
        for (int k = 0; k < NR; k++) do_read(k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_avmm_responder.md
# csr_avmm_responder

Avalon-MM slave that sits between the sequencer's host bus and its bank of read/write CSR registers. It decodes word addresses into one-hot register selects and expands byte enables into per-bit write enables, issuing a single-cycle write strobe per accepted write. It muxes the register bank's outputs back as read data with a fixed latency and flags out-of-range accesses.

## Interface
- P_NUM_REGS, 8, number of CSR registers decoded (word addresses 0..P_NUM_REGS-1)
- P_DATA_WIDTH, 32, register/bus data width; must be a multiple of 8
- P_ADDR_WIDTH, 4, word-address width; must be ≥ clog2(P_NUM_REGS)
- CLOCK  input  1  block clock
- RESET_N  input  1  reset, asynchronous, active-low
- AVS_ADDRESS  input  P_ADDR_WIDTH  word address
- AVS_READ  input  1  read command
- AVS_WRITE  input  1  write command
- AVS_WRITEDATA  input  P_DATA_WIDTH  write data
- AVS_BYTEENABLE  input  P_DATA_WIDTH/8  byte enables
- AVS_WAITREQUEST  output  1  low for exactly the accept cycle of a command
- AVS_READDATA  output  P_DATA_WIDTH  read data
- AVS_READDATAVALID  output  1  one-cycle read-data qualifier
- AVS_RESPONSE  output  2  2'b00 OKAY, 2'b10 SLVERR; valid with READDATAVALID
- REG_SELECT  output  P_NUM_REGS  one-hot register select
- REG_WRITE  output  1  one-cycle write strobe
- REG_ENA  output  P_DATA_WIDTH  per-bit write enable, byte enable replicated ×8
- REG_DATA  output  P_DATA_WIDTH  write data to registers
- REG_RDATA  input  P_NUM_REGS*P_DATA_WIDTH  packed register outputs; register k at bits [k*W +: W]

## Operation
- Reset values:
  - AVS_WAITREQUEST = 1.
  - AVS_READDATAVALID = 0.
  - AVS_READDATA, AVS_RESPONSE, REG_SELECT, REG_WRITE, REG_ENA, REG_DATA = 0.
- All outputs are registered.
- FSM states: IDLE, ACK, RVALID.
- IDLE:
  - WAITREQUEST = 1.
  - When AVS_WRITE or AVS_READ is sampled high, latch address, writedata and byteenable, then go to ACK.
  - If both are high, treat the command as a write; the read is never answered (protocol violation).
- ACK (exactly one cycle): WAITREQUEST = 0.
  - In-range write: REG_SELECT = 1<<addr, REG_WRITE = 1, REG_ENA and REG_DATA driven. Return to IDLE.
  - Out-of-range write: REG_SELECT = 0, REG_WRITE = 0. Return to IDLE.
  - Read: capture the REG_RDATA slice, or 0 if out of range. Set response to OKAY, or SLVERR if out of range. Go to RVALID.
- RVALID (one cycle): READDATAVALID = 1 with READDATA and RESPONSE. Return to IDLE.
- Outside ACK, REG_SELECT, REG_WRITE and REG_ENA are 0. REG_DATA holds its last value.
- READDATA and RESPONSE hold their last value after RVALID.
- A write with all byte enables 0 still pulses REG_WRITE, with REG_ENA = 0.
- Command changes after capture (master dropping read/write in ACK) are ignored; the latched command completes.
- Reset asserted in any state returns to IDLE with reset values on the next evaluation. An in-flight read is dropped with no READDATAVALID.

## Timing
- Cycle 0: command sampled high in IDLE.
- Cycle 1 (ACK): WAITREQUEST low; REG_WRITE high for a write. The register updates at the end of cycle 1, and its new value is visible on REG_RDATA in cycle 2.
- Read: REG_RDATA is sampled at the end of cycle 1; READDATAVALID is high in cycle 2. Read latency from accept is 1 cycle.
- Throughput:
  - Write: next command may be sampled in cycle 2, so 2 cycles per write.
  - Read: next command may be sampled in cycle 3, so 3 cycles per read.
- Read-after-write to the same register returns the new value.

## Structure
- Shared package csr_pkg holds:
  - state enum (IDLE/ACK/RVALID),
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10,
  - function be_to_bitmask(byteenable) → P_DATA_WIDTH mask.
- One natural sub-module, csr_addr_decode (combinational), maps address to a one-hot select plus an in_range flag.
- The FSM, latches and read mux live in the top module.

## Test plan
- Reset with the bus idle → WAITREQUEST=1, READDATAVALID=0, all other outputs 0.
- Write addr 2, data 0xA5A5_1234, BE 4'hF → in cycle 1: WAITREQUEST=0, REG_SELECT=8'h04, REG_WRITE=1, REG_ENA=32'hFFFF_FFFF, REG_DATA=0xA5A5_1234. All four are 0/1 (idle) in cycle 2.
- Write addr 0, BE 4'b0010 → REG_ENA=32'h0000_FF00 and REG_SELECT=8'h01 for one cycle; BE 4'b0000 → REG_WRITE=1 with REG_ENA=0.
- Read addr 5 with slice 5 = 0xDEAD_BEEF → READDATAVALID high in cycle 2 only, READDATA=0xDEAD_BEEF, RESPONSE=2'b00.
- Read addr 9 (P_NUM_REGS=8) → READDATA=0, RESPONSE=2'b10; write addr 9 → REG_WRITE stays 0 and WAITREQUEST still pulses low once.
- Write addr 3 then an immediate read of addr 3 returns the written value; a second read with RESET_N pulsed low during its ACK produces no READDATAVALID and all outputs return to reset values.
